// File: rtl/uart_pkg.sv
// Shared types and frame constants for the uart_core TX/RX state machines.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_CLEANUP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_CLEANUP
    } rx_state_t;

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer: counts 0..limit-1, flags the last count and wraps to 0,
// so a state that keeps the timer running lasts exactly 'limit' clocks.
module uart_baud_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    assign expire = (cnt == limit - 1'b1);

    // Free-running count held at zero while cleared, wrapping on expiry
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART (transmitter + receiver) sharing one baud parameter.
// Optional build macro UART_CORE_LOOPBACK_EN adds i_Loopback, which feeds the
// receiver from the transmitter's line instead of i_RX_Serial.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done,
    input  logic       i_RX_Serial,
`ifdef UART_CORE_LOOPBACK_EN
    input  logic       i_Loopback,
`endif
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    // ---------------- transmitter ----------------
    tx_state_t  tx_state, tx_state_n;
    logic [7:0] tx_byte, tx_byte_n;
    logic [2:0] tx_idx, tx_idx_n;
    logic       tx_clear, tx_expire;

    uart_baud_timer #(.CNT_W(CNT_W)) u_tx_timer (
        .clk    (i_Clock),
        .rst_n  (i_Rst_n),
        .clear  (tx_clear),
        .limit  (FULL_BIT),
        .expire (tx_expire)
    );

    // TX state register; the latched byte is payload and needs no reset
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            tx_state <= TX_IDLE;
            tx_idx   <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_idx   <= tx_idx_n;
        end
        tx_byte <= tx_byte_n;
    end

    // TX next state and line outputs decoded from the current state
    always_comb begin
        tx_state_n  = tx_state;
        tx_byte_n   = tx_byte;
        tx_idx_n    = tx_idx;
        tx_clear    = 1'b0;
        o_TX_Serial = STOP_BIT;
        o_TX_Active = 1'b0;
        o_TX_Done   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_clear = 1'b1;
                tx_idx_n = '0;
                if (i_TX_DV) begin
                    tx_byte_n  = i_TX_Byte;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                o_TX_Serial = START_BIT;
                o_TX_Active = 1'b1;
                if (tx_expire) tx_state_n = TX_DATA;
            end
            TX_DATA: begin
                o_TX_Serial = tx_byte[tx_idx];
                o_TX_Active = 1'b1;
                if (tx_expire) begin
                    if (tx_idx == LAST_IDX) tx_state_n = TX_STOP;
                    else                    tx_idx_n   = tx_idx + 1'b1;
                end
            end
            TX_STOP: begin
                o_TX_Active = 1'b1;
                if (tx_expire) tx_state_n = TX_CLEANUP;
            end
            TX_CLEANUP: begin
                o_TX_Done  = 1'b1;
                tx_clear   = 1'b1;
                tx_state_n = TX_IDLE;
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    logic rx_line;
`ifdef UART_CORE_LOOPBACK_EN
    assign rx_line = i_Loopback ? (o_TX_Active ? o_TX_Serial : 1'b1) : i_RX_Serial;
`else
    assign rx_line = i_RX_Serial;
`endif

    logic       rx_sync_p0, rx_sync_p1;
    rx_state_t  rx_state, rx_state_n;
    logic [7:0] rx_shift, rx_shift_n;
    logic [7:0] rx_byte, rx_byte_n;
    logic [2:0] rx_idx, rx_idx_n;
    logic       rx_dv, rx_dv_n;
    logic       rx_armed, rx_armed_n;
    logic       rx_clear, rx_expire;
    logic [CNT_W-1:0] rx_limit;

    uart_baud_timer #(.CNT_W(CNT_W)) u_rx_timer (
        .clk    (i_Clock),
        .rst_n  (i_Rst_n),
        .clear  (rx_clear),
        .limit  (rx_limit),
        .expire (rx_expire)
    );

    // Two-flop synchronizer for the asynchronous serial input; idles high
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx_line;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    // RX state and output registers; the shift register is payload only
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            rx_state <= RX_IDLE;
            rx_idx   <= '0;
            rx_byte  <= '0;
            rx_dv    <= 1'b0;
            rx_armed <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_idx   <= rx_idx_n;
            rx_byte  <= rx_byte_n;
            rx_dv    <= rx_dv_n;
            rx_armed <= rx_armed_n;
        end
        rx_shift <= rx_shift_n;
    end

    // RX next state: a start needs a high-then-low in IDLE (rx_armed), so a
    // line stuck low never retriggers after a framing error
    always_comb begin
        rx_state_n = rx_state;
        rx_shift_n = rx_shift;
        rx_byte_n  = rx_byte;
        rx_idx_n   = rx_idx;
        rx_dv_n    = 1'b0;
        rx_armed_n = rx_armed;
        rx_clear   = 1'b0;
        rx_limit   = FULL_BIT;
        case (rx_state)
            RX_IDLE: begin
                rx_clear = 1'b1;
                rx_idx_n = '0;
                if (rx_sync_p1 == START_BIT && rx_armed) begin
                    rx_armed_n = 1'b0;
                    rx_state_n = RX_START;
                end else if (rx_sync_p1 == STOP_BIT) begin
                    rx_armed_n = 1'b1;
                end
            end
            RX_START: begin
                rx_limit = HALF_BIT;
                if (rx_expire) begin
                    if (rx_sync_p1 == START_BIT) rx_state_n = RX_DATA;
                    else                         rx_state_n = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (rx_expire) begin
                    rx_shift_n = {rx_sync_p1, rx_shift[7:1]};
                    if (rx_idx == LAST_IDX) rx_state_n = RX_STOP;
                    else                    rx_idx_n   = rx_idx + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_expire) begin
                    if (rx_sync_p1 == STOP_BIT) begin
                        rx_byte_n = rx_shift;
                        rx_dv_n   = 1'b1;
                    end
                    rx_state_n = RX_CLEANUP;
                end
            end
            RX_CLEANUP: begin
                rx_clear   = 1'b1;
                rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    assign o_RX_DV   = rx_dv;
    assign o_RX_Byte = rx_byte;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: directed and random frames on TX, RX and
// an external loopback of the TX line, checked against a frame-level model.
module tb_uart_core;

    localparam int CPB = 217;

    logic       clk = 1'b0;
    logic       i_Rst_n = 1'b0;
    logic       i_TX_DV = 1'b0;
    logic [7:0] i_TX_Byte = 8'h00;
    logic       o_TX_Active, o_TX_Serial, o_TX_Done;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       loop_mode = 1'b0;
    logic       rx_drive = 1'b1;
    logic       rx_pin;
    logic       tb_loopback = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rx_got[$];
    logic [7:0] rx_exp[$];
    logic [7:0] last_good = 8'h00;

    assign rx_pin = loop_mode ? (o_TX_Active ? o_TX_Serial : 1'b1) : rx_drive;

    always #5 clk = ~clk;

    uart_core #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (i_Rst_n),
        .i_TX_DV     (i_TX_DV),
        .i_TX_Byte   (i_TX_Byte),
        .o_TX_Active (o_TX_Active),
        .o_TX_Serial (o_TX_Serial),
        .o_TX_Done   (o_TX_Done),
        .i_RX_Serial (rx_pin),
`ifdef UART_CORE_LOOPBACK_EN
        .i_Loopback  (tb_loopback),
`endif
        .o_RX_DV     (o_RX_DV),
        .o_RX_Byte   (o_RX_Byte)
    );

    // Collect every received byte, one entry per DV cycle
    always @(negedge clk) begin
        if (o_RX_DV === 1'b1) rx_got.push_back(o_RX_Byte);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expect a byte on the RX side and remember it as the held output value
    task automatic expect_rx(input logic [7:0] b);
        rx_exp.push_back(b);
        last_good = b;
    endtask

    task automatic check_rx(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_rx_count"}, 32'(rx_got.size()), 32'(rx_exp.size()));
        for (int k = 0; k < rx_exp.size() && k < rx_got.size(); k++)
            check({tag, "_rx_byte"}, 32'(rx_got[k]), 32'(rx_exp[k]));
        check({tag, "_rx_hold"}, 32'(o_RX_Byte), 32'(last_good));
        rx_got.delete();
        rx_exp.delete();
    endtask

    // Transmit one byte starting from the next negedge and watch the whole
    // frame: Active width, line level at each bit centre, Done timing.
    // inject_at >= 0 pulses DV with inj_byte at that offset into the frame.
    task automatic tx_frame(input string tag, input logic [7:0] b,
                            input int inject_at, input logic [7:0] inj_byte);
        logic [9:0] exp_bits;
        logic [9:0] got;
        int act;
        int early_done;
        exp_bits   = {1'b1, b, 1'b0};
        got        = '0;
        act        = 0;
        early_done = 0;
        @(negedge clk);
        i_TX_Byte = b;
        i_TX_DV   = 1'b1;
        @(negedge clk);
        i_TX_DV   = 1'b0;
        for (int i = 0; i < 10 * CPB; i++) begin
            if (o_TX_Active === 1'b1) act++;
            if (o_TX_Done === 1'b1) early_done++;
            if (i % CPB == CPB / 2) got[i / CPB] = o_TX_Serial;
            if (i == inject_at) begin
                i_TX_Byte = inj_byte;
                i_TX_DV   = 1'b1;
            end else begin
                i_TX_DV = 1'b0;
            end
            @(negedge clk);
        end
        i_TX_DV = 1'b0;
        check({tag, "_active_clocks"}, 32'(act), 32'(10 * CPB));
        check({tag, "_bit_centres"}, 32'(got), 32'(exp_bits));
        check({tag, "_early_done"}, 32'(early_done), 32'd0);
        check({tag, "_done"}, 32'(o_TX_Done), 32'd1);
        check({tag, "_active_off"}, 32'(o_TX_Active), 32'd0);
    endtask

    // Drive one frame on the RX pin after one idle-high bit time
    task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        rx_drive = 1'b1;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            rx_drive = fr[k];
            repeat (CPB) @(negedge clk);
        end
        rx_drive = 1'b1;
    endtask

    initial begin
        logic [7:0] rb;
        logic       ok;
        int         n_done;
        int         n_low;

        // Reset values
        i_Rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_serial", 32'(o_TX_Serial), 32'd1);
        check("rst_active", 32'(o_TX_Active), 32'd0);
        check("rst_done",   32'(o_TX_Done),   32'd0);
        check("rst_rx_dv",  32'(o_RX_DV),     32'd0);
        check("rst_rx_byte", 32'(o_RX_Byte),  32'd0);
        i_Rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // External loopback, then a directed pattern
        loop_mode = 1'b1;
        tx_frame("loop_3f", 8'h3F, -1, 8'h00);
        expect_rx(8'h3F);
        check_rx("loop_3f");
        tx_frame("tx_a5", 8'hA5, -1, 8'h00);
        expect_rx(8'hA5);
        check_rx("tx_a5");

        // Reset in the middle of the data bits of an 8'hFF frame
        loop_mode = 1'b0;
        repeat (10) @(negedge clk);
        i_TX_Byte = 8'hFF;
        i_TX_DV   = 1'b1;
        @(negedge clk);
        i_TX_DV   = 1'b0;
        repeat (600) @(negedge clk);
        check("midrst_active_before", 32'(o_TX_Active), 32'd1);
        i_Rst_n = 1'b0;
        @(negedge clk);
        i_Rst_n = 1'b1;
        check("midrst_serial", 32'(o_TX_Serial), 32'd1);
        check("midrst_active", 32'(o_TX_Active), 32'd0);
        n_done = 0;
        n_low  = 0;
        for (int i = 0; i < 2000; i++) begin
            if (o_TX_Done === 1'b1) n_done++;
            if (o_TX_Serial !== 1'b1) n_low++;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(n_done), 32'd0);
        check("midrst_line_idle", 32'(n_low), 32'd0);
        last_good = 8'h00;
        loop_mode = 1'b1;
        tx_frame("after_rst", 8'h5A, -1, 8'h00);
        expect_rx(8'h5A);
        check_rx("after_rst");

        // 100-clock glitch on the RX pin, then a real frame
        loop_mode = 1'b0;
        rx_drive  = 1'b0;
        repeat (100) @(negedge clk);
        rx_drive  = 1'b1;
        repeat (400) @(negedge clk);
        check_rx("glitch");
        rx_frame(8'h81, 1'b1);
        expect_rx(8'h81);
        check_rx("after_glitch");

        // Framing error keeps the previous byte, next frame still received
        rx_frame(8'h55, 1'b0);
        check_rx("framing_err");
        rx_frame(8'hC3, 1'b1);
        expect_rx(8'hC3);
        check_rx("after_framing");

        // DV while busy is ignored; then two back-to-back frames
        loop_mode = 1'b1;
        tx_frame("busy_12", 8'h12, 1000, 8'h00);
        expect_rx(8'h12);
        tx_frame("b2b_01", 8'h01, -1, 8'h00);
        expect_rx(8'h01);
        tx_frame("b2b_02", 8'h02, -1, 8'h00);
        expect_rx(8'h02);
        check_rx("busy_b2b");

        // Random bytes through the looped-back transmitter
        for (int n = 0; n < 5; n++) begin
            rb = 8'($urandom_range(0, 255));
            tx_frame("rand_tx", rb, -1, 8'h00);
            expect_rx(rb);
        end
        check_rx("rand_tx");

        // Random frames on the RX pin, some with a bad stop bit
        loop_mode = 1'b0;
        for (int n = 0; n < 5; n++) begin
            rb = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            rx_frame(rb, ok);
            if (ok) expect_rx(rb);
        end
        repeat (CPB) @(negedge clk);
        check_rx("rand_rx");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Full-duplex 8N1 UART: one transmitter and one receiver in a single clock domain, sharing one baud-rate parameter.
- Sits between a byte-level host interface (valid pulse in, valid pulse out) and the two serial pins.
- Default is 115200 baud from a 25 MHz clock (217 clocks per bit).

Parameters:
- CLKS_PER_BIT, 217, clocks per serial bit (clock freq / baud). Legal range is 4 or more.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Rst_n  in  1  synchronous, active-low reset.
- i_TX_DV  in  1  one-cycle request to transmit i_TX_Byte.
- i_TX_Byte  in  8  byte to send.
- o_TX_Active  out  1  high while a frame is on the line.
- o_TX_Serial  out  1  serial output; idles high.
- o_TX_Done  out  1  one-cycle pulse after the stop bit completes.
- i_RX_Serial  in  1  serial input; asynchronous to i_Clock.
- o_RX_DV  out  1  one-cycle pulse when o_RX_Byte is valid.
- o_RX_Byte  out  8  last received byte; held until the next valid byte.

Behaviour:
- Reset (i_Rst_n=0 at a clock edge):
  - Both FSMs go to IDLE.
  - Outputs: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_RX_DV=0, o_RX_Byte=0.
  - Counters and synchronizer flops are cleared; synchronizer flops clear to 1.
  - Reset mid-frame aborts the frame immediately.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Every bit lasts exactly CLKS_PER_BIT clocks.
- TX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: line high. When i_TX_DV=1, latch i_TX_Byte and go to START. o_TX_Active rises on the following edge, together with o_TX_Serial falling.
  - START: drive 0 for CLKS_PER_BIT clocks.
  - DATA: drive bit[idx], idx 0..7, each for CLKS_PER_BIT clocks, then go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT clocks. On exit, pulse o_TX_Done for 1 cycle and drop o_TX_Active.
  - CLEANUP: one cycle, then IDLE. The next frame can start on the cycle after Done.
  - i_TX_DV outside IDLE is ignored (no queueing).
  - Total frame length: 10*CLKS_PER_BIT clocks of line time.
- RX path:
  - i_RX_Serial passes through a 2-flop synchronizer.
  - RX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: a synchronized low moves to START.
  - START: wait (CLKS_PER_BIT-1)/2 clocks (integer division), then resample. If still low, the start bit is valid; reset the counter and go to DATA. If high, treat it as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT clocks, which lands at bit centre. Shift into bit[idx], LSB first. After 8 bits go to STOP.
  - STOP: wait CLKS_PER_BIT clocks and sample. If 1, update o_RX_Byte and pulse o_RX_DV for 1 cycle. If 0 (framing error), discard the byte: no DV, o_RX_Byte unchanged.
  - CLEANUP: one cycle, then IDLE.
  - Line held low permanently: no DV is produced, and RX re-arms only after the line has been seen high in IDLE. A falling edge is required, not just a low level.
  - o_RX_DV rises roughly 9.5 bit times after the start edge, plus 2 synchronizer cycles.
- TX and RX are fully independent. Simultaneous TX and RX activity is legal.

Optional Feature:
- Macro: UART_CORE_LOOPBACK_EN.
- Defined: adds input port i_Loopback (1 bit).
  - When i_Loopback=1, the RX input is (o_TX_Active ? o_TX_Serial : 1'b1) and i_RX_Serial is ignored.
  - o_TX_Serial still drives the pin.
- Not defined: no i_Loopback port; RX always uses i_RX_Serial.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t and rx_state_t enums (IDLE, START, DATA, STOP, CLEANUP).
  - Constants DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1.
- Natural sub-module: uart_baud_timer.
  - Counts 0..limit-1 and asserts expire.
  - Loadable limit, used for full-bit and half-bit waits.
  - Instantiated once in TX and once in RX.

Test Plan:
- Loopback (line = TX_Active ? TX_Serial : 1), pulse TX_DV with 8'h3F -> one RX_DV pulse with o_RX_Byte=8'h3F; TX_Done 2170 clocks after TX_Active rises.
- Send 8'hA5 and sample o_TX_Serial at bit centres -> 0,1,0,1,0,0,1,0,1,1; TX_Active high for exactly 2170 clocks.
- Drive a 100-clock low glitch on i_RX_Serial -> RX returns to IDLE, no RX_DV; a following valid frame 8'h81 is received correctly.
- Send frame 8'h55 with stop bit forced 0 -> no RX_DV, o_RX_Byte keeps its previous value; next frame 8'hC3 is received.
- Assert i_Rst_n=0 for 1 cycle mid-DATA of an 8'hFF transmit -> next cycle o_TX_Serial=1, TX_Active=0, no TX_Done; a new TX_DV then completes normally.
- Pulse i_TX_DV with 8'h00 while busy sending 8'h12 -> only 8'h12 is transmitted; back-to-back frames 8'h01 and 8'h02 (DV on the cycle after Done) are both received in order.
